// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle processor control FSM (optional bne: MULTICYCLE_CTRL_BNE_EN)
module multicycle_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b1100;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
`ifdef MULTICYCLE_CTRL_BNE_EN
    BNEEX,
`endif
    JEX
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;
  logic       wait_done;

  logic       pcwrite;
  logic       branch;
  logic       branch_ne;
  logic       irwrite_raw;
  logic       memwrite_raw;
  logic       regwrite_raw;
  logic       illegal_raw;

  logic       rtype_ok;
  logic [3:0] rtype_alu;

  assign wait_done = (cnt == LAST_WAIT);

  // R-type function field decode: legality and ALU operation
  always_comb begin
    rtype_ok  = 1'b1;
    rtype_alu = ALU_ADD;
    case (funct)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_ok  = 1'b0;
    endcase
  end

  // State register and wait counter; the counter restarts whenever the state changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? 4'd0 : cnt + 4'd1;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    nxt          = state;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = ALU_ADD;
    illegal_raw  = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    branch_ne    = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = 2'b01;
        if (wait_done) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
          nxt         = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE: begin
            if (rtype_ok) begin
              nxt = RTYPEEX;
            end else begin
              illegal_raw = 1'b1;
              nxt         = FETCH;
            end
          end
          OP_BEQ:  nxt = BEQEX;
          OP_ADDI: nxt = ADDIEX;
          OP_J:    nxt = JEX;
`ifdef MULTICYCLE_CTRL_BNE_EN
          OP_BNE:  nxt = BNEEX;
`endif
          default: begin
            illegal_raw = 1'b1;
            nxt         = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (wait_done) nxt = MEMWB;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        nxt          = FETCH;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        nxt          = FETCH;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        nxt        = RTYPEWB;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        nxt          = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        nxt        = FETCH;
      end
`ifdef MULTICYCLE_CTRL_BNE_EN
      BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch_ne  = 1'b1;
        nxt        = FETCH;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        nxt          = FETCH;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        nxt     = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  // Write enables are suppressed while reset is held, even in the final FETCH cycle
  assign pcen     = rst_n & (pcwrite | (branch & zero) | (branch_ne & ~zero));
  assign irwrite  = rst_n & irwrite_raw;
  assign memwrite = rst_n & memwrite_raw;
  assign regwrite = rst_n & regwrite_raw;
  assign illegal  = rst_n & illegal_raw;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized model-checked bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6, K_BNE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst3;
  logic [5:0] op1, funct1, op3, funct3;
  logic       zero1, zero3;

  logic       pcen1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1, illegal1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [3:0] alucontrol1;
  logic       pcen3, iord3, memwrite3, irwrite3, regdst3, memtoreg3, regwrite3, alusrca3, illegal3;
  logic [1:0] alusrcb3, pcsrc3;
  logic [3:0] alucontrol3;

  multicycle_ctrl #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst1), .op(op1), .funct(funct1), .zero(zero1),
    .pcen(pcen1), .iord(iord1), .memwrite(memwrite1), .irwrite(irwrite1),
    .regdst(regdst1), .memtoreg(memtoreg1), .regwrite(regwrite1), .alusrca(alusrca1),
    .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucontrol(alucontrol1), .illegal(illegal1)
  );

  multicycle_ctrl #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst3), .op(op3), .funct(funct3), .zero(zero3),
    .pcen(pcen3), .iord(iord3), .memwrite(memwrite3), .irwrite(irwrite3),
    .regdst(regdst3), .memtoreg(memtoreg3), .regwrite(regwrite3), .alusrca(alusrca3),
    .alusrcb(alusrcb3), .pcsrc(pcsrc3), .alucontrol(alucontrol3), .illegal(illegal3)
  );

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal}
  logic [16:0] v1, v3;
  assign v1 = {pcen1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1,
               alusrcb1, pcsrc1, alucontrol1, illegal1};
  assign v3 = {pcen3, iord3, memwrite3, irwrite3, regdst3, memtoreg3, regwrite3, alusrca3,
               alusrcb3, pcsrc3, alucontrol3, illegal3};

  localparam logic [16:0] RST_VEC = {8'b0, 2'b01, 2'b00, 4'b0000, 1'b0};

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                         f == 6'b100101 || f == 6'b101010) ? K_RT : K_ILL;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
`ifdef MULTICYCLE_CTRL_BNE_EN
      6'b000101: return K_BNE;
`endif
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int instr_len(input int k, input int l);
    case (k)
      K_LW:                 return 2 * l + 3;
      K_SW, K_RT, K_ADDI:   return l + 3;
      K_BEQ, K_BNE, K_J:    return l + 2;
      default:              return l + 1;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 4'b0001;
      6'b100100: return 4'b0100;
      6'b100101: return 4'b0101;
      6'b101010: return 4'b1100;
      default:   return 4'b0000;
    endcase
  endfunction

  // Expected outputs for cycle idx (0-based) of an instruction of class k
  function automatic logic [16:0] exp_vec(input int k, input int idx, input int l,
                                          input logic [5:0] f, input logic z);
    logic pc, io, mw, irw, rd, m2r, rw, sa, il;
    logic [1:0] sb, ps;
    logic [3:0] alu;
    int e;
    {pc, io, mw, irw, rd, m2r, rw, sa, il} = '0;
    sb = 2'b00; ps = 2'b00; alu = 4'b0000;
    e = idx - l - 1;
    if (idx < l) begin
      sb = 2'b01;
      if (idx == l - 1) begin irw = 1'b1; pc = 1'b1; end
    end else if (idx == l) begin
      sb = 2'b11;
      il = (k == K_ILL);
    end else begin
      case (k)
        K_LW: begin
          if (e == 0) begin sa = 1'b1; sb = 2'b10; end
          else if (e <= l) io = 1'b1;
          else begin m2r = 1'b1; rw = 1'b1; end
        end
        K_SW: begin
          if (e == 0) begin sa = 1'b1; sb = 2'b10; end
          else begin io = 1'b1; mw = 1'b1; end
        end
        K_RT: begin
          if (e == 0) begin sa = 1'b1; alu = alu_of(f); end
          else begin rd = 1'b1; rw = 1'b1; end
        end
        K_BEQ, K_BNE: begin
          sa = 1'b1; alu = 4'b0001; ps = 2'b01;
          pc = (k == K_BEQ) ? z : ~z;
        end
        K_ADDI: begin
          if (e == 0) begin sa = 1'b1; sb = 2'b10; end
          else rw = 1'b1;
        end
        K_J: begin ps = 2'b10; pc = 1'b1; end
        default: ;
      endcase
    end
    return {pc, io, mw, irw, rd, m2r, rw, sa, sb, ps, alu, il};
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_LW: return "lw";   K_SW: return "sw";   K_RT: return "rtype";
      K_BEQ: return "beq"; K_ADDI: return "addi"; K_J: return "j";
      K_BNE: return "bne"; default: return "illegal";
    endcase
  endfunction

  task automatic drive(input int sel, input logic [5:0] o, input logic [5:0] f, input logic z);
    if (sel == 3) begin op3 = o; funct3 = f; zero3 = z; end
    else begin op1 = o; funct1 = f; zero1 = z; end
  endtask

  // Runs one instruction from its first FETCH cycle; called at posedge+1.
  // zmode < 0 randomizes zero each cycle; stop_at < 0 runs to completion.
  task automatic run_instr(input int sel, input logic [5:0] iop, input logic [5:0] ifn,
                           input int zmode, input int stop_at);
    int l, k, n;
    logic z;
    logic junk;
    logic [16:0] got;
    l = (sel == 3) ? 3 : 1;
    k = classify(iop, ifn);
    n = instr_len(k, l);
    if (stop_at >= 0 && stop_at < n) n = stop_at;
    for (int i = 0; i < n; i++) begin
      z = (zmode < 0) ? 1'($urandom) : zmode[0];
      junk = (i < l) || (k == K_LW && i > l + 1);
      if (junk) drive(sel, 6'($urandom), 6'($urandom), z);
      else drive(sel, iop, ifn, z);
      @(negedge clk);
      got = (sel == 3) ? v3 : v1;
      check($sformatf("%s L%0d c%0d", kname(k), l, i), {15'b0, got}, {15'b0, exp_vec(k, i, l, ifn, z)});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pick(output logic [5:0] o, output logic [5:0] f);
    logic [5:0] legal_f [5];
    legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    f = 6'($urandom);
    case ($urandom_range(0, 9))
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: begin o = 6'b000000; f = legal_f[$urandom_range(0, 4)]; end
      3: o = 6'b000100;
      4: o = 6'b001000;
      5: o = 6'b000010;
      6: o = 6'b000101;
      7: o = 6'b111111;
      8: o = 6'b000000;
      default: o = 6'($urandom);
    endcase
  endtask

  initial begin
    logic [5:0] ro, rf;
    rst1 = 1'b0; rst3 = 1'b0;
    drive(1, 6'b100011, 6'b0, 1'b1);
    drive(3, 6'b100011, 6'b0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("reset lat1", {15'b0, v1}, {15'b0, RST_VEC});
      check("reset lat3", {15'b0, v3}, {15'b0, RST_VEC});
    end
    @(posedge clk);
    #1;
    rst1 = 1'b1;

    // Directed cases with MEM_LAT = 1
    run_instr(1, 6'b100011, 6'b000000, -1, -1);
    run_instr(1, 6'b000000, 6'b101010, -1, -1);
    run_instr(1, 6'b000100, 6'b000000,  1, -1);
    run_instr(1, 6'b000100, 6'b000000,  0, -1);
    run_instr(1, 6'b111111, 6'b000000, -1, -1);
    run_instr(1, 6'b000000, 6'b000000, -1, -1);
    run_instr(1, 6'b000101, 6'b000000,  1, -1);
    run_instr(1, 6'b000101, 6'b000000,  0, -1);
    run_instr(1, 6'b000010, 6'b000000, -1, -1);
    for (int n = 0; n < 60; n++) begin
      pick(ro, rf);
      run_instr(1, ro, rf, -1, -1);
    end

    // Directed cases with MEM_LAT = 3
    rst3 = 1'b1;
    run_instr(3, 6'b101011, 6'b000000, -1, -1);
    run_instr(3, 6'b100011, 6'b000000, -1, -1);
    run_instr(3, 6'b001000, 6'b000000, -1, -1);

    // Reset during MEMRD cycle 2 of a load, then a clean restart
    run_instr(3, 6'b100011, 6'b000000, -1, 6);
    drive(3, 6'b100011, 6'b000000, 1'b1);
    #2;
    rst3 = 1'b0;
    #1;
    check("async reset in memrd", {15'b0, v3}, {15'b0, RST_VEC});
    @(negedge clk);
    check("held reset", {15'b0, v3}, {15'b0, RST_VEC});
    @(posedge clk);
    #1;
    rst3 = 1'b1;
    run_instr(3, 6'b100011, 6'b000000, -1, -1);

    for (int n = 0; n < 40; n++) begin
      pick(ro, rf);
      run_instr(3, ro, rf, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 MEM_LAT, default 1, memory access latency in cycles; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 op  input  6  opcode from instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pcen  output  1  PC write enable.
REQ-008 iord  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-009 memwrite  output  1  data memory write enable.
REQ-010 irwrite  output  1  instruction register write enable.
REQ-011 regdst  output  1  write register select: 0 rt, 1 rd.
REQ-012 memtoreg  output  1  writeback select: 0 ALUOut, 1 data register.
REQ-013 regwrite  output  1  register file write enable.
REQ-014 alusrca  output  1  ALU A select: 0 PC, 1 register A.
REQ-015 alusrcb  output  2  ALU B select: 00 B, 01 constant 4, 10 signimm, 11 signimm<<2.
REQ-016 pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-017 alucontrol  output  4  ALU operation code.
REQ-018 illegal  output  1  high for one cycle on an undecodable instruction.

Function
REQ-019 Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX. Exceptions: pcen (REQ-029) and illegal/alucontrol, which also depend combinationally on zero, op and funct.
REQ-020 Every output not listed for a state is 0 in that state.
REQ-021 FETCH: iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00. Held MEM_LAT cycles by a wait counter. irwrite=1 and pcwrite=1 on the final cycle only. Next state DECODE.
REQ-022 DECODE: alusrca=0, alusrcb=11, ALU add. Next state by op:
- 100011/101011 -> MEMADR
- 000000 with funct in {100000,100010,100100,100101,101010} -> RTYPEEX
- 000100 -> BEQEX
- 001000 -> ADDIEX
- 000010 -> JEX
- otherwise illegal=1, -> FETCH
REQ-023 MEMADR: alusrca=1, alusrcb=10, ALU add. Next state MEMRD if op=100011, else MEMWR.
REQ-024 MEMRD: iord=1, held MEM_LAT cycles, -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1, -> FETCH.
REQ-025 MEMWR: iord=1, memwrite=1, one cycle, -> FETCH.
REQ-026 RTYPEEX: alusrca=1, alusrcb=00, alucontrol decoded from funct, -> RTYPEWB. RTYPEWB: regdst=1, memtoreg=0, regwrite=1, -> FETCH.
REQ-027 BEQEX: alusrca=1, alusrcb=00, ALU sub, pcsrc=01, branch=1, -> FETCH.
REQ-028 ADDIEX: alusrca=1, alusrcb=10, ALU add, -> ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1, -> FETCH. JEX: pcsrc=10, pcwrite=1, -> FETCH.
REQ-029 pcen = pcwrite OR (branch AND zero), combinational in the same cycle.
REQ-030 alucontrol encoding: add 0000, sub 0001, and 0100, or 0101, slt 1100.
- funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- States not using the ALU drive 0000.
REQ-031 Wait counter clears on every state entry; MEM_LAT=1 adds no cycles.
REQ-032 Cycles per instruction (L = MEM_LAT): lw 2L+3; sw, R-type, addi L+3; beq, j L+2; illegal L+1.
REQ-033 op and funct are decoded only in DECODE, MEMADR and RTYPEEX; changes in other states have no effect.

Reset
REQ-034 rst_n low asynchronously forces state FETCH, wait counter 0, illegal 0.
REQ-035 While rst_n is low, pcen, irwrite, memwrite and regwrite are forced 0; all other outputs take FETCH values.
REQ-036 Reset mid-instruction abandons that instruction; the first rising edge after release is FETCH cycle 1.

Configuration
REQ-037 Macro MULTICYCLE_CTRL_BNE_EN.
- Defined: op 000101 in DECODE -> BNEEX, which matches BEQEX except pcen = branch AND NOT zero.
- Undefined: op 000101 is illegal.

Verification
REQ-038 MEM_LAT=1, op=100011 -> 5 cycles FETCH..MEMWB; irwrite=pcen=1 in cycle 1 only; regwrite=memtoreg=1 in cycle 5 only.
REQ-039 op=000000, funct=101010 -> RTYPEEX alucontrol=1100, then RTYPEWB regdst=1, regwrite=1; 4 cycles total.
REQ-040 op=000100: zero=1 in BEQEX -> pcen=1, alucontrol=0001, pcsrc=01; zero=0 -> pcen=0; 3 cycles.
REQ-041 MEM_LAT=3, op=101011 -> FETCH 3 cycles, irwrite only in cycle 3; MEMWR memwrite=iord=1 for one cycle; 6 cycles total.
REQ-042 op=111111, or op=000000 with funct=000000 -> illegal=1 for one DECODE cycle, back to FETCH, no regwrite/memwrite. op=000101 -> BNEEX with macro defined, illegal without.
REQ-043 MEM_LAT=3, rst_n low in MEMRD cycle 2 -> enables 0 immediately; after release FETCH lasts 3 cycles.
